// File: rtl/cv32e40p_idx_accum_pkg.sv
// Shared types for the index accumulator: FSM state encoding.
package cv32e40p_pkg;

  typedef enum logic [0:0] {
    IDX_ACC_COLLECT = 1'b0,
    IDX_ACC_DRAIN   = 1'b1
  } idx_accum_state_e;

endpackage

// File: rtl/cv32e40p_idx_accum_if.sv
// Index-in / mask-out handshake bundle for cv32e40p_idx_accum.
interface cv32e40p_idx_accum_if #(
  parameter int LEN = 32
);
  localparam int IDX_W = $clog2(LEN);

  logic             idx_valid_i;
  logic             idx_ready_o;
  logic [IDX_W-1:0] idx_i;
  logic             idx_last_i;
  logic             mask_valid_o;
  logic             mask_ready_i;
  logic [LEN-1:0]   mask_o;
  logic [IDX_W:0]   count_o;
  logic             dup_o;
  logic             oor_o;

  modport slave (
    input  idx_valid_i, idx_i, idx_last_i, mask_ready_i,
    output idx_ready_o, mask_valid_o, mask_o, count_o, dup_o, oor_o
  );

  modport master (
    output idx_valid_i, idx_i, idx_last_i, mask_ready_i,
    input  idx_ready_o, mask_valid_o, mask_o, count_o, dup_o, oor_o
  );
endinterface

// File: rtl/cv32e40p_idx_decode.sv
// Index to one-hot decoder; indices >= LEN decode to zero and flag oor_o.
module cv32e40p_idx_decode #(
  parameter  int LEN   = 32,
  localparam int IDX_W = $clog2(LEN)
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [LEN-1:0]   onehot_o,
  output logic             oor_o
);

  for (genvar i = 0; i < LEN; i++) begin : g_bit
    assign onehot_o[i] = (idx_i == IDX_W'(i));
  end

  assign oor_o = ({1'b0, idx_i} >= (IDX_W+1)'(LEN));

endmodule

// File: rtl/cv32e40p_idx_accum.sv
// Rebuilds a LEN-bit vector from a stream of bit indices and hands it
// downstream once the last beat arrives or the vector fills up.
module cv32e40p_idx_accum
  import cv32e40p_pkg::*;
#(
  parameter  int LEN   = 32,
  localparam int IDX_W = $clog2(LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  cv32e40p_idx_accum_if.slave  bus
);

  localparam logic [0:0] COLLECT = IDX_ACC_COLLECT;
  localparam logic [0:0] DRAIN   = IDX_ACC_DRAIN;

  logic [0:0]     state_q;
  logic [LEN-1:0] mask_q;
  logic [IDX_W:0] count_q;
  logic           dup_q, oor_q;

  logic [LEN-1:0] onehot, mask_nxt;
  logic           dec_oor, accept, hit, new_bit, full;

  cv32e40p_idx_decode #(.LEN(LEN)) i_decode (
    .idx_i    (bus.idx_i),
    .onehot_o (onehot),
    .oor_o    (dec_oor)
  );

  assign accept   = bus.idx_valid_i && (state_q == COLLECT);
  assign hit      = |(onehot & mask_q);
  assign new_bit  = !hit && !dec_oor;
  assign mask_nxt = mask_q | onehot;
  assign full     = &mask_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      mask_q  <= '0;
      count_q <= '0;
      dup_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      // status pulses only ever follow an accepted beat
      dup_q <= accept && hit;
      oor_q <= accept && dec_oor;
      case (state_q)
        COLLECT: begin
          if (accept) begin
            mask_q  <= mask_nxt;
            count_q <= count_q + {{IDX_W{1'b0}}, new_bit};
            if (bus.idx_last_i || full) state_q <= DRAIN;
          end
        end
        default: begin
          if (bus.mask_ready_i) begin
            mask_q  <= '0;
            count_q <= '0;
            state_q <= COLLECT;
          end
        end
      endcase
    end
  end

  assign bus.idx_ready_o  = (state_q == COLLECT);
  assign bus.mask_valid_o = (state_q == DRAIN);
  assign bus.mask_o       = mask_q;
  assign bus.count_o      = count_q;
  assign bus.dup_o        = dup_q;
  assign bus.oor_o        = oor_q;

endmodule

// File: tb/tb_cv32e40p_idx_accum.sv
// Directed and random checks of cv32e40p_idx_accum at LEN=32 and LEN=5.
module tb_cv32e40p_idx_accum;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cv32e40p_idx_accum_if #(.LEN(32)) ia ();
  cv32e40p_idx_accum_if #(.LEN(5))  ib ();

  cv32e40p_idx_accum #(.LEN(32)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  cv32e40p_idx_accum #(.LEN(5))  dut_b (.clk(clk), .rst(rst), .bus(ib));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input int idx, input bit last);
    ia.idx_valid_i = 1'b1;
    ia.idx_i       = 5'(idx);
    ia.idx_last_i  = last;
    step();
    ia.idx_valid_i = 1'b0;
    ia.idx_last_i  = 1'b0;
  endtask

  task automatic beat_b(input int idx, input bit last);
    ib.idx_valid_i = 1'b1;
    ib.idx_i       = 3'(idx);
    ib.idx_last_i  = last;
    step();
    ib.idx_valid_i = 1'b0;
    ib.idx_last_i  = 1'b0;
  endtask

  initial begin
    logic [31:0] model;
    bit          acc, drn;
    int          dup_cnt;

    rst = 1'b1;
    ia.idx_valid_i = 1'b0; ia.idx_i = '0; ia.idx_last_i = 1'b0; ia.mask_ready_i = 1'b0;
    ib.idx_valid_i = 1'b0; ib.idx_i = '0; ib.idx_last_i = 1'b0; ib.mask_ready_i = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_mask",   ia.mask_o, 0);
    chk("rst_count",  ia.count_o, 0);
    chk("rst_ready",  ia.idx_ready_o, 1);
    chk("rst_mvalid", ia.mask_valid_o, 0);
    chk("rst_dup",    ia.dup_o, 0);
    chk("rst_oor",    ia.oor_o, 0);

    // basic: 3, 17, 31(last), downstream always ready
    ia.mask_ready_i = 1'b1;
    beat_a(3, 0);
    chk("b_mvalid_mid", ia.mask_valid_o, 0);
    beat_a(17, 0);
    beat_a(31, 1);
    chk("b_mvalid", ia.mask_valid_o, 1);
    chk("b_mask",   ia.mask_o, 64'h8002_0008);
    chk("b_count",  ia.count_o, 3);
    chk("b_ready0", ia.idx_ready_o, 0);
    step();
    chk("b_ready1",  ia.idx_ready_o, 1);
    chk("b_mvalid0", ia.mask_valid_o, 0);
    chk("b_cleared", ia.mask_o, 0);

    // duplicates: 5, 5, 9(last)
    ia.mask_ready_i = 1'b0;
    dup_cnt = 0;
    beat_a(5, 0);
    chk("d_dup_first", ia.dup_o, 0);
    beat_a(5, 0);
    chk("d_dup_pulse", ia.dup_o, 1);
    chk("d_count_mid", ia.count_o, 1);
    beat_a(9, 1);
    chk("d_dup_clear", ia.dup_o, 0);
    chk("d_mask",   ia.mask_o, 64'h220);
    chk("d_count",  ia.count_o, 2);
    chk("d_mvalid", ia.mask_valid_o, 1);
    ia.mask_ready_i = 1'b1;
    step();
    ia.mask_ready_i = 1'b0;

    // auto-drain once every bit is set, no last
    for (int i = 0; i < 32; i++) beat_a(i, 0);
    chk("a_mvalid", ia.mask_valid_o, 1);
    chk("a_mask",   ia.mask_o, 64'hFFFF_FFFF);
    chk("a_count",  ia.count_o, 32);
    ia.idx_valid_i = 1'b1;
    ia.idx_i       = 5'd7;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("a_hold_ready", ia.idx_ready_o, 0);
      chk("a_hold_mask",  ia.mask_o, 64'hFFFF_FFFF);
      chk("a_hold_valid", ia.mask_valid_o, 1);
      chk("a_hold_dup",   ia.dup_o, 0);
    end
    ia.idx_valid_i  = 1'b0;
    ia.mask_ready_i = 1'b1;
    step();
    ia.mask_ready_i = 1'b0;
    chk("a_drained", ia.mask_o, 0);
    chk("a_ready",   ia.idx_ready_o, 1);

    // out-of-range on LEN=5
    beat_b(6, 0);
    chk("o_oor_pulse", ib.oor_o, 1);
    chk("o_mask_mid",  ib.mask_o, 0);
    beat_b(2, 1);
    chk("o_oor_clear", ib.oor_o, 0);
    chk("o_mask",   ib.mask_o, 64'b00100);
    chk("o_count",  ib.count_o, 1);
    chk("o_mvalid", ib.mask_valid_o, 1);
    ib.mask_ready_i = 1'b1;
    step();
    ib.mask_ready_i = 1'b0;
    beat_b(7, 1);
    chk("e_oor",    ib.oor_o, 1);
    chk("e_dup",    ib.dup_o, 0);
    chk("e_mvalid", ib.mask_valid_o, 1);
    chk("e_mask",   ib.mask_o, 0);
    chk("e_count",  ib.count_o, 0);
    ib.mask_ready_i = 1'b1;
    step();
    ib.mask_ready_i = 1'b0;

    // reset during collect, then during drain
    beat_a(1, 0);
    beat_a(4, 0);
    chk("r_mask_pre", ia.mask_o, 64'h12);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r_mask",  ia.mask_o, 0);
    chk("r_count", ia.count_o, 0);
    chk("r_ready", ia.idx_ready_o, 1);
    beat_a(2, 1);
    chk("r_drain", ia.mask_valid_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r_mvalid", ia.mask_valid_o, 0);
    chk("r_mask2",  ia.mask_o, 0);

    // random scoreboard
    model = '0;
    for (int c = 0; c < 10000; c++) begin
      ia.idx_valid_i  = ($urandom_range(0, 3) != 0);
      ia.idx_i        = 5'($urandom_range(0, 31));
      ia.idx_last_i   = ($urandom_range(0, 7) == 0);
      ia.mask_ready_i = ($urandom_range(0, 1) == 1);
      acc = ia.idx_valid_i && ia.idx_ready_o;
      drn = ia.mask_valid_o && ia.mask_ready_i;
      if (drn) begin
        chk("rnd_drain_mask", ia.mask_o, 64'(model));
        model = '0;
      end
      if (acc) model = model | (32'd1 << ia.idx_i);
      step();
      chk("rnd_popcount", 64'(ia.count_o), 64'($countones(ia.mask_o)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_idx_accum.md
Name: cv32e40p_idx_accum

Overview:
- Converts a stream of bit indices back into a LEN-bit vector. This is the inverse of the find-first-one encoder.
- Accepts one index per cycle over a valid/ready handshake and ORs its one-hot decode into an accumulating mask.
- Presents the completed mask downstream over a second valid/ready handshake.
- Used to rebuild pending/claim bitmaps (e.g. interrupt-pending or ID-allocation vectors) from index streams.

Parameters:
- LEN, 32, width of the reconstructed vector. Any value >= 2; need not be a power of 2.
- IDX_W, $clog2(LEN), index width. Derived; not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- idx_valid_i  input  1  index beat valid.
- idx_ready_o  output  1  block can accept an index beat.
- idx_i  input  IDX_W  bit index to set.
- idx_last_i  input  1  final beat of the current mask.
- mask_valid_o  output  1  accumulated mask available.
- mask_ready_i  input  1  downstream consumes the mask.
- mask_o  output  LEN  accumulated vector.
- count_o  output  IDX_W+1  number of distinct bits set in mask_o.
- dup_o  output  1  one-cycle pulse: previous accepted index was already set.
- oor_o  output  1  one-cycle pulse: previous accepted index was >= LEN.

Behaviour:
- States: COLLECT and DRAIN. Held in a 1-bit registered FSM.
- Reset (synchronous, rst=1 at the edge):
  - state=COLLECT, mask_o=0, count_o=0, dup_o=0, oor_o=0.
  - Reset overrides any handshake in the same cycle, including mid-collect and mid-drain. A pending mask is discarded.
- COLLECT:
  - idx_ready_o=1, mask_valid_o=0.
  - Accept = idx_valid_i & idx_ready_o.
  - On accept with idx_i < LEN and bit clear: set mask bit idx_i; count_o += 1.
  - On accept with bit already set: mask and count unchanged; dup_o=1 in the next cycle.
  - On accept with idx_i >= LEN (only possible when LEN is not a power of 2): beat dropped; oor_o=1 in the next cycle.
  - dup_o and oor_o are 0 in every cycle not following such an accept. They are never both 1.
- COLLECT -> DRAIN at the edge of an accept where either condition holds:
  - idx_last_i=1, regardless of dup/oor status; or
  - the updated mask becomes all ones (count reaches LEN). This is an auto-drain.
- Latency: last beat accepted at edge N gives mask_valid_o=1 and the updated mask_o in cycle N+1. No combinational path from idx_* to mask_*.
- DRAIN:
  - idx_ready_o=0, mask_valid_o=1.
  - mask_o and count_o are held stable until mask_ready_i=1.
  - On mask_ready_i=1: mask_o=0, count_o=0, state=COLLECT at that edge.
  - The next index is accepted no earlier than the following cycle (one bubble per mask).
- An empty mask is legal: a single out-of-range beat with last gives mask_valid_o with mask_o=0 and count_o=0.
- Sticky-free: dup_o and oor_o do not affect the FSM.
- Invariant: count_o == popcount(mask_o) in every cycle.

Decomposition:
- Package cv32e40p_pkg gains:
  - enum idx_accum_state_e {IDX_ACC_COLLECT, IDX_ACC_DRAIN}.
- One sub-module, cv32e40p_idx_decode (combinational):
  - Inputs: idx_i.
  - Outputs: onehot_o [LEN] and oor_o.
  - Same LEN parameter. Reusable wherever an index must be turned back into a vector.
- Accumulator, counter and FSM stay in cv32e40p_idx_accum.

Test Plan:
- LEN=32:
  - Stimulus: indices 3, 17, 31 back-to-back, last on 31, mask_ready_i=1.
  - Expected: mask_valid_o one cycle after the 31 accept; mask_o=0x8002_0008, count_o=3; idx_ready_o=0 in that cycle and 1 in the next.
- LEN=32, duplicates:
  - Stimulus: indices 5, 5, 9 (last).
  - Expected: dup_o pulses exactly once, one cycle after the second 5; mask_o=0x0000_0220, count_o=2.
- LEN=32, auto-drain:
  - Stimulus: indices 0..31 without last.
  - Expected: DRAIN entered after index 31 with mask_o=0xFFFF_FFFF, count_o=32; idx_ready_o=0 while mask_ready_i is held 0 for 5 cycles; mask stable throughout.
- LEN=5, out-of-range:
  - Stimulus: indices 6 then 2 (last).
  - Expected: oor_o pulse one cycle after the 6; mask_o=5'b00100, count_o=1. A lone 7 with last gives mask_o=0, count_o=0, mask_valid_o=1.
- Reset mid-operation:
  - Stimulus: collect 1, 4, then assert rst for one cycle.
  - Expected: next cycle mask_o=0, count_o=0, idx_ready_o=1. Repeat with rst asserted during DRAIN while mask_ready_i=0: mask_valid_o=0 after reset.
- Random scoreboard:
  - Stimulus: 10k random beats with random valid/last/ready.
  - Expected: every drained mask equals the OR of the one-hots of its accepted beats; count_o == popcount(mask_o) in every cycle.
